// File: rtl/lib_allocator_output_first_islip.sv
// Output-first separable NxM allocator with iterative iSLIP matching.
// Ports: clk, reset_n, i_start, i_request[N][M] -> o_busy, o_valid, o_grant[M][N].
module lib_allocator_output_first_islip #(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int ITER = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [N-1:0][M-1:0]   i_request,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [M-1:0][N-1:0]   o_grant
);

    localparam int PWN = $clog2(N);
    localparam int PWM = $clog2(M);
    localparam int KW  = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ITERATE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0][M-1:0] req_q;
    logic [M-1:0][N-1:0] match_q;
    logic [M-1:0][N-1:0] grant_q;
    logic [M-1:0][N-1:0] offer;
    logic [M-1:0][N-1:0] acc;
    logic [PWN-1:0]      g_q [M];
    logic [PWN-1:0]      g_d [M];
    logic [PWM-1:0]      a_q [N];
    logic [PWM-1:0]      a_d [N];
    logic [KW-1:0]       k_q;
    logic [M-1:0]        out_m;
    logic [N-1:0]        in_m;
    logic                valid_q;
    logic                start_ok;
    logic                last_iter;

    // o_valid is seen while already back in IDLE; it still counts as busy
    assign start_ok  = (state_q == IDLE) && i_start && !valid_q;
    assign last_iter = (k_q == KW'(ITER - 1));
    assign o_busy    = (state_q != IDLE) || valid_q;
    assign o_valid   = valid_q;
    assign o_grant   = grant_q;

    always_comb begin
        out_m = '0;
        in_m  = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                if (match_q[m][n]) begin
                    out_m[m] = 1'b1;
                    in_m[n]  = 1'b1;
                end
            end
        end
    end

    // Offer: round-robin from g[m] over unmatched requesting inputs
    always_comb begin
        logic found;
        int   idx;
        offer = '0;
        for (int m = 0; m < M; m++) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                idx = (int'(g_q[m]) + j) % N;
                if (!found && !out_m[m] && req_q[idx][m] && !in_m[idx]) begin
                    offer[m][idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    // Accept: round-robin from a[n] over offering outputs
    always_comb begin
        logic found;
        int   idx;
        acc = '0;
        for (int n = 0; n < N; n++) begin
            found = 1'b0;
            for (int j = 0; j < M; j++) begin
                idx = (int'(a_q[n]) + j) % M;
                if (!found && !in_m[n] && offer[idx][n]) begin
                    acc[idx][n] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    // Pointers move only on first-iteration accepts (iSLIP desync rule)
    always_comb begin
        for (int m = 0; m < M; m++) g_d[m] = g_q[m];
        for (int n = 0; n < N; n++) a_d[n] = a_q[n];
        if (k_q == '0) begin
            for (int m = 0; m < M; m++) begin
                for (int n = 0; n < N; n++) begin
                    if (acc[m][n]) begin
                        g_d[m] = PWN'((n + 1) % N);
                        a_d[n] = PWM'((m + 1) % M);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = ITERATE;
            ITERATE: if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= '0;
            match_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            k_q     <= '0;
            for (int m = 0; m < M; m++) g_q[m] <= '0;
            for (int n = 0; n < N; n++) a_q[n] <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        req_q   <= i_request;
                        match_q <= '0;
                        k_q     <= '0;
                    end
                end
                ITERATE: begin
                    match_q <= match_q | acc;
                    k_q     <= k_q + KW'(1);
                    for (int m = 0; m < M; m++) g_q[m] <= g_d[m];
                    for (int n = 0; n < N; n++) a_q[n] <= a_d[n];
                end
                DONE: begin
                    grant_q <= match_q;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lib_allocator_output_first_islip.sv
// Randomized self-checking bench for the output-first iSLIP allocator.
// Compares grants and latency with an array-based reference model.
module tb_lib_allocator_output_first_islip;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int ITER = 2;

    logic                clk;
    logic                reset_n;
    logic                i_start;
    logic [N-1:0][M-1:0] i_request;
    logic                o_busy;
    logic                o_valid;
    logic [M-1:0][N-1:0] o_grant;

    int n_cmp = 0;
    int n_bad = 0;
    int gp [M];
    int ap [N];

    lib_allocator_output_first_islip #(
        .N(N), .M(M), .ITER(ITER)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_request(i_request),
        .o_busy(o_busy),
        .o_valid(o_valid),
        .o_grant(o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < M; m++) gp[m] = 0;
        for (int n = 0; n < N; n++) ap[n] = 0;
    endtask

    // Reference: ITER rounds of offer/accept on plain int arrays
    function automatic logic [M-1:0][N-1:0] ref_alloc(
        input logic [N-1:0][M-1:0] r);
        logic [M-1:0][N-1:0] g;
        bit ou [M];
        bit iu [N];
        int off [M];
        int c;
        g = '0;
        for (int m = 0; m < M; m++) ou[m] = 0;
        for (int n = 0; n < N; n++) iu[n] = 0;
        for (int it = 0; it < ITER; it++) begin
            for (int m = 0; m < M; m++) begin
                off[m] = -1;
                if (!ou[m]) begin
                    for (int j = 0; j < N; j++) begin
                        c = (gp[m] + j) % N;
                        if (off[m] < 0 && r[c][m] && !iu[c]) off[m] = c;
                    end
                end
            end
            for (int n = 0; n < N; n++) begin
                if (!iu[n]) begin
                    int pick;
                    pick = -1;
                    for (int j = 0; j < M; j++) begin
                        c = (ap[n] + j) % M;
                        if (pick < 0 && off[c] == n) pick = c;
                    end
                    if (pick >= 0) begin
                        g[pick][n] = 1'b1;
                        ou[pick]   = 1;
                        iu[n]      = 1;
                        if (it == 0) begin
                            gp[pick] = (n + 1) % N;
                            ap[n]    = (pick + 1) % M;
                        end
                    end
                end
            end
        end
        return g;
    endfunction

    task automatic run(input string tag, input logic [N-1:0][M-1:0] r,
                       output logic [M-1:0][N-1:0] got);
        logic [M-1:0][N-1:0] exp;
        int lat;
        exp = ref_alloc(r);
        @(posedge clk);
        #1;
        i_start   = 1'b1;
        i_request = r;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_request = N*M'($urandom);
        check({tag, " busy"}, 64'(o_busy), 64'd1);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(ITER + 1));
        check({tag, " grant"}, 64'(o_grant), 64'(exp));
        got = o_grant;
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, 64'(o_valid), 64'd0);
        check({tag, " hold"}, 64'(o_grant), 64'(got));
        check({tag, " idle"}, 64'(o_busy), 64'd0);
    endtask

    task automatic check_props(input logic [N-1:0][M-1:0] r,
                               input logic [M-1:0][N-1:0] g);
        int bad_row, bad_col, bad_req, cnt;
        bad_row = 0;
        bad_col = 0;
        bad_req = 0;
        for (int m = 0; m < M; m++) begin
            cnt = 0;
            for (int n = 0; n < N; n++) begin
                cnt += int'(g[m][n]);
                if (g[m][n] && !r[n][m]) bad_req++;
            end
            if (cnt > 1) bad_row++;
        end
        for (int n = 0; n < N; n++) begin
            cnt = 0;
            for (int m = 0; m < M; m++) cnt += int'(g[m][n]);
            if (cnt > 1) bad_col++;
        end
        check("row_onehot", 64'(bad_row), 64'd0);
        check("col_onehot", 64'(bad_col), 64'd0);
        check("grant_req", 64'(bad_req), 64'd0);
    endtask

    initial begin
        logic [M-1:0][N-1:0] g;
        logic [M-1:0][N-1:0] g1;
        logic [N-1:0][M-1:0] r;
        int vcnt;

        reset_n   = 1'b0;
        i_start   = 1'b0;
        i_request = '0;
        model_reset();
        #23;
        check("rst valid", 64'(o_valid), 64'd0);
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst grant", 64'(o_grant), 64'd0);
        reset_n = 1'b1;

        run("empty1", '0, g);
        check("empty1 zero", 64'(g), 64'd0);
        run("empty2", '0, g1);
        check("empty2 same", 64'(g1), 64'(g));

        run("ones1", '1, g);
        check("ones1 lit", 64'(g), 64'h0021);
        run("ones2", '1, g);
        check("ones2 lit", 64'(g), 64'h0412);

        r = '0;
        r[2][3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run("single", r, g);
            check("single lit", 64'(g), 64'h4000);
        end

        // i2->o0 alone leaves g[0]=3 for the wrap case
        r = '0;
        r[2][0] = 1'b1;
        run("wrap_set", r, g);
        r = '0;
        r[0][0] = 1'b1;
        r[3][0] = 1'b1;
        run("wrap1", r, g);
        check("wrap1 lit", 64'(g), 64'h0008);
        run("wrap2", r, g);
        check("wrap2 lit", 64'(g), 64'h0001);

        // start held through the whole run: exactly one result
        r = N*M'($urandom);
        g1 = ref_alloc(r);
        @(posedge clk);
        #1;
        i_start   = 1'b1;
        i_request = r;
        vcnt = 0;
        for (int c = 0; c < ITER + 2; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) vcnt++;
        end
        check("hold grant", 64'(o_grant), 64'(g1));
        i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) vcnt++;
        end
        check("hold vcnt", 64'(vcnt), 64'd1);

        // reset in the middle of ITERATE
        @(posedge clk);
        #1;
        i_start   = 1'b1;
        i_request = '1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid valid", 64'(o_valid), 64'd0);
        check("mid busy", 64'(o_busy), 64'd0);
        check("mid grant", 64'(o_grant), 64'd0);
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) vcnt++;
        end
        check("mid vcnt", 64'(vcnt), 64'd0);
        reset_n = 1'b1;
        model_reset();
        run("post_rst", '1, g);
        check("post_rst lit", 64'(g), 64'h0021);

        for (int i = 0; i < 1000; i++) begin
            r = N*M'($urandom);
            if (i % 3 == 0) r = r & N*M'($urandom);
            run("rand", r, g);
            check_props(r, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
